// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: takes one command from the controller, runs the
// SETUP/ACCESS handshake on the selected slave, and returns a one-cycle response.
module apb_master_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wr,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [SEL_WIDTH-1:0]  i_req_sel,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [NUM_SLAVES-1:0] o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic [DATA_WIDTH-1:0] i_prdata,
    input  logic                  i_pready,
    input  logic                  i_pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [SEL_WIDTH:0] NUM_SEL  = (SEL_WIDTH+1)'(NUM_SLAVES);
    localparam logic [3:0]         WAIT_MAX = 4'(TIMEOUT);

    state_t                state, state_nx;
    logic [SEL_WIDTH-1:0]  sel_q, sel_src;
    logic [NUM_SLAVES-1:0] sel_dec;
    logic [3:0]            wait_cnt;
    logic                  accept, sel_ok;

    assign accept  = i_req_valid && o_req_ready;
    assign sel_ok  = {1'b0, i_req_sel} < NUM_SEL;
    // On the accept edge the captured select is not loaded yet, so decode the input.
    assign sel_src = (state == IDLE) ? i_req_sel : sel_q;

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel_dec[i] = (sel_src == SEL_WIDTH'(i));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = sel_ok ? SETUP : RESP;
            SETUP:   state_nx = ACCESS;
            // Ready wins over timeout on the same cycle.
            ACCESS:  if (i_pready || wait_cnt == WAIT_MAX) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_paddr     <= '0;
            o_psel      <= '0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_pwdata    <= '0;
            sel_q       <= '0;
            wait_cnt    <= '0;
        end else begin
            o_req_ready <= (state_nx == IDLE);
            o_rsp_valid <= (state_nx == RESP);
            o_penable   <= (state_nx == ACCESS);
            o_psel      <= (state_nx == SETUP || state_nx == ACCESS) ? sel_dec : '0;

            if (accept) begin
                o_paddr  <= i_req_addr;
                o_pwrite <= i_req_wr;
                o_pwdata <= i_req_wdata;
                sel_q    <= i_req_sel;
            end

            if (state_nx == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && !i_pready)
                wait_cnt <= wait_cnt + 4'd1;

            if (state == ACCESS && state_nx == RESP) begin
                o_rsp_rdata <= (i_pready && !o_pwrite) ? i_prdata : '0;
                o_rsp_err   <= i_pready ? i_pslverr : 1'b1;
            end else if (state == IDLE && state_nx == RESP) begin
                o_rsp_rdata <= '0;
                o_rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of the data bus.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, giving the width of the address bus.
REQ-003 The block SHALL have parameter SEL_WIDTH, default 2, giving the width of the slave-index field.
REQ-004 The block SHALL have parameter NUM_SLAVES, default 2, giving the number of attached slaves; the legal index range is 0..NUM_SLAVES-1.
REQ-005 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of ACCESS wait cycles before abort.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous active-high reset.
REQ-007 The block SHALL have these controller-side ports:
- i_req_valid  in  1  command request from the controller.
- o_req_ready  out  1  bridge can accept a command.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_WIDTH  slave register address.
- i_req_sel  in  SEL_WIDTH  target slave index.
- i_req_wdata  in  DATA_WIDTH  write data.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- o_rsp_err  out  1  transfer failed.
REQ-008 The block SHALL have these APB-side ports:
- o_paddr  out  ADDR_WIDTH  APB address.
- o_psel  out  NUM_SLAVES  one-hot slave select.
- o_penable  out  1  APB enable.
- o_pwrite  out  1  APB write.
- o_pwdata  out  DATA_WIDTH  APB write data.
- i_prdata  in  DATA_WIDTH  read data, pre-muxed by slave.
- i_pready  in  1  slave ready.
- i_pslverr  in  1  slave error.

Function
REQ-009 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be registered.
REQ-010 o_req_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where i_req_valid and o_req_ready are both 1.
REQ-011 On accept, the block SHALL capture addr, wr, wdata and sel into internal registers; later changes on the req_* inputs SHALL be ignored until the next accept.
REQ-012 An accept with i_req_sel < NUM_SLAVES SHALL move the FSM IDLE -> SETUP: o_psel[sel]=1, o_penable=0, with o_paddr, o_pwrite and o_pwdata driven from the captured values.
REQ-013 SETUP SHALL last exactly one cycle and then move to ACCESS, where o_penable=1 and o_psel, o_paddr, o_pwrite and o_pwdata stay unchanged.
REQ-014 In ACCESS with i_pready=1, the block SHALL:
- set o_rsp_rdata=i_prdata for a read, or 0 for a write;
- set o_rsp_err=i_pslverr;
- move to RESP.
REQ-015 In ACCESS with i_pready=0, a 4-bit wait counter SHALL increment; when the counter equals TIMEOUT and i_pready is still 0, the block SHALL abort to RESP with o_rsp_err=1 and o_rsp_rdata=0.
REQ-016 The wait counter SHALL clear on entry to SETUP; i_pready=1 on the cycle the counter reaches TIMEOUT SHALL complete normally (ready wins over timeout).
REQ-017 In RESP, o_rsp_valid=1 for exactly one cycle, o_psel=0 and o_penable=0; the FSM SHALL then return to IDLE.
REQ-018 An accept with i_req_sel >= NUM_SLAVES SHALL move IDLE -> RESP directly, with no APB activity, o_rsp_err=1 and o_rsp_rdata=0.
REQ-019 Latency SHALL be: accept at cycle N, SETUP at N+1, ACCESS at N+2, o_rsp_valid at N+3+W, where W is the number of wait cycles; an illegal select gives o_rsp_valid at N+1.
REQ-020 Back-to-back operation: the next accept SHALL be possible on the cycle after RESP, so the minimum spacing between accepts is 4 cycles.
REQ-021 o_rsp_rdata and o_rsp_err SHALL hold their values until the next RESP.
REQ-022 At most one bit of o_psel SHALL be 1 at any time, and o_penable=1 SHALL imply o_psel != 0.

Reset
REQ-023 With i_rst=1 at a rising edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 except o_req_ready=1; the wait counter and captured registers SHALL clear to 0.
REQ-024 A reset during SETUP, ACCESS or RESP SHALL abandon the transfer: no o_rsp_valid is produced and o_psel/o_penable are 0 from the next cycle.

Verification
REQ-025 Write, zero-wait: accept wr=1, addr=0x0003, sel=1, wdata=0xBEEF; i_pready=1 -> o_psel=2'b10 with o_penable 0 then 1; o_rsp_valid at N+3; o_rsp_err=0; o_rsp_rdata=0.
REQ-026 Read, 3 waits: accept wr=0, addr=0x0005, sel=0; i_pready held 0 for 3 ACCESS cycles, then 1 with i_prdata=0x1234 -> o_rsp_valid at N+6; o_rsp_rdata=0x1234; o_penable high for 4 cycles.
REQ-027 Timeout: i_pready held at 0 -> ACCESS lasts TIMEOUT+1 cycles, then o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata=0.
REQ-028 Illegal select and slave error:
- sel=3 -> o_psel stays 0; o_rsp_valid at N+1 with o_rsp_err=1.
- Separately, i_pready=1 with i_pslverr=1 -> o_rsp_err=1.
REQ-029 Reset mid-ACCESS: assert i_rst for 1 cycle -> o_psel=0, o_penable=0, o_req_ready=1, no o_rsp_valid; a following request completes normally.
REQ-030 Request hold: i_req_valid held at 1 across a transfer, with i_req_addr changing during SETUP -> o_paddr stays at the captured value; the second accept occurs on the cycle after RESP.
